// File: rtl/systolic_matmul_core.sv
// systolic_matmul_core: NxN output-stationary systolic matmul with byte-stream load and result drain.
// Define SYSMM_SIGNED_EN for two's-complement operands; unsigned otherwise.
module systolic_matmul_core #(
  parameter int N = 2,
  parameter int DATA_W = 8,
  parameter int ACC_W = 2*DATA_W+2
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_data,
  input  logic              acc_keep,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [ACC_W-1:0]  out_data,
  output logic              busy,
  output logic              done
);
  localparam int NN = N*N;
  localparam int EW = $clog2(NN);
  localparam logic [4:0] LAST_E = 5'(NN-1);
  localparam logic [4:0] LAST_T = 5'(3*N-3);
  typedef enum logic [2:0] {IDLE, LOAD_A, LOAD_B, COMPUTE, DRAIN} state_t;
  state_t state, state_n;
  logic [4:0] cnt, cnt_n;
  logic [EW-1:0] eidx;
  logic in_fire, out_fire, step, last;
  logic [DATA_W-1:0] a_mem [NN];
  logic [DATA_W-1:0] b_mem [NN];
  logic [DATA_W-1:0] a_pipe [N][N-1];
  logic [DATA_W-1:0] b_pipe [N-1][N];
  logic [DATA_W-1:0] a_op [N][N];
  logic [DATA_W-1:0] b_op [N][N];
  logic [ACC_W-1:0] acc [NN];

  function automatic logic [ACC_W-1:0] mul(input logic [DATA_W-1:0] a, input logic [DATA_W-1:0] b);
`ifdef SYSMM_SIGNED_EN
    return {{(ACC_W-DATA_W){a[DATA_W-1]}}, a} * {{(ACC_W-DATA_W){b[DATA_W-1]}}, b};
`else
    return {{(ACC_W-DATA_W){1'b0}}, a} * {{(ACC_W-DATA_W){1'b0}}, b};
`endif
  endfunction

  assign eidx      = cnt[EW-1:0];
  assign in_ready  = state == IDLE || state == LOAD_A || state == LOAD_B;
  assign out_valid = state == DRAIN;
  assign out_data  = out_valid ? acc[eidx] : '0;
  assign busy      = state != IDLE;
  assign in_fire   = in_valid && in_ready;
  assign out_fire  = out_valid && out_ready;

  always_comb begin
    step    = in_fire || out_fire || state == COMPUTE;
    last    = state == COMPUTE ? cnt == LAST_T : cnt == LAST_E;
    cnt_n   = step ? (last ? 5'd0 : cnt + 5'd1) : cnt;
    state_n = step && (last || state == IDLE) ? (state == DRAIN ? IDLE : state_t'(state + 3'd1)) : state;
  end

  // Skewed injection: row i of A and column j of B enter i (resp. j) cycles late, zeros elsewhere.
  always_comb begin
    for (int i = 0; i < N; i++)
      for (int j = 0; j < N; j++) begin
        a_op[i][j] = '0;
        b_op[i][j] = '0;
      end
    for (int i = 0; i < N; i++)
      for (int k = 0; k < N; k++) begin
        if (state == COMPUTE && int'(cnt) == i+k) a_op[i][0] = a_mem[i*N+k];
        if (state == COMPUTE && int'(cnt) == i+k) b_op[0][i] = b_mem[k*N+i];
      end
    for (int i = 0; i < N; i++)
      for (int j = 1; j < N; j++) begin
        a_op[i][j] = a_pipe[i][j-1];
        b_op[j][i] = b_pipe[j-1][i];
      end
  end

  always_ff @(posedge clk) begin
    if ((state == IDLE || state == LOAD_A) && in_fire) a_mem[eidx] <= in_data;
    if (state == LOAD_B && in_fire) b_mem[eidx] <= in_data;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      cnt   <= '0;
      done  <= 1'b0;
      for (int i = 0; i < N; i++)
        for (int j = 0; j < N-1; j++) begin
          a_pipe[i][j] <= '0;
          b_pipe[j][i] <= '0;
        end
      for (int e = 0; e < NN; e++) acc[e] <= '0;
    end else begin
      state <= state_n;
      cnt   <= cnt_n;
      done  <= out_fire && cnt == LAST_E;
      for (int i = 0; i < N; i++)
        for (int j = 0; j < N-1; j++) begin
          a_pipe[i][j] <= a_op[i][j];
          b_pipe[j][i] <= b_op[j][i];
        end
      for (int i = 0; i < N; i++)
        for (int j = 0; j < N; j++)
          if (state == IDLE && in_fire && !acc_keep) acc[i*N+j] <= '0;
          else if (state == COMPUTE) acc[i*N+j] <= acc[i*N+j] + mul(a_op[i][j], b_op[i][j]);
    end
  end
endmodule

// File: tb/tb_systolic_matmul_core.sv
// tb_systolic_matmul_core: directed and randomized jobs checked against a plain matrix-product model.
module tb_systolic_matmul_core;
  localparam int N = 2, DW = 8, AW = 2*DW+2, NN = N*N;
  logic clk = 0, rst, in_valid, in_ready, acc_keep, out_valid, out_ready, busy, done;
  logic [DW-1:0] in_data;
  logic [AW-1:0] out_data;
  int cyc = 0, cmp = 0, bad = 0;
  logic [DW-1:0] ma [NN];
  logic [DW-1:0] mb [NN];
  logic [AW-1:0] mc [NN];
  logic [AW-1:0] got [NN];

  systolic_matmul_core #(.N(N), .DATA_W(DW), .ACC_W(AW)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
    .acc_keep(acc_keep), .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
    .busy(busy), .done(done));

  always #5 clk = ~clk;
  always @(posedge clk) cyc++;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    cmp++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  function automatic longint ext(input logic [DW-1:0] v);
`ifdef SYSMM_SIGNED_EN
    return longint'($signed(v));
`else
    return longint'(v);
`endif
  endfunction

  task automatic model(input bit keep);
    for (int i = 0; i < N; i++)
      for (int j = 0; j < N; j++) begin
        longint s = keep ? longint'(mc[i*N+j]) : 0;
        for (int k = 0; k < N; k++) s += ext(ma[i*N+k]) * ext(mb[k*N+j]);
        mc[i*N+j] = AW'(s);
      end
  endtask

  task automatic do_abort();
    @(negedge clk);
    in_valid = 0; out_ready = 0; rst = 1;
    @(negedge clk);
    rst = 0;
    chk("abort_out_valid", out_valid, 0);
    chk("abort_busy", busy, 0);
    chk("abort_in_ready", in_ready, 1);
    chk("abort_out_data", out_data, 0);
    chk("abort_done", done, 0);
    for (int e = 0; e < NN; e++) mc[e] = '0;
  endtask

  task automatic run_job(input bit keep, input int gap, input int stall, input int abort);
    int sent = 0, lastb = 0, n = 0, t = 0;
    bit hold = 0;
    logic [AW-1:0] held = '0;
    while (sent < 2*NN && t < 500) begin
      @(negedge clk);
      t++;
      in_valid = $urandom_range(99) >= gap;
      in_data = sent < NN ? ma[sent] : mb[sent-NN];
      acc_keep = keep;
      if (in_valid && in_ready) begin
        lastb = cyc;
        sent++;
      end
      if (abort == 1 && sent == NN+1) begin
        do_abort();
        return;
      end
    end
    chk("load_count", sent, 2*NN);
    model(keep);
    t = 0;
    do begin
      @(negedge clk);
      t++;
      if (!out_valid) begin
        chk("ready_compute", {in_ready, busy}, 2'b01);
        in_valid = 1'($urandom_range(1));
        in_data = DW'($urandom());
      end
    end while (!out_valid && t < 40);
    in_valid = 0;
    chk("latency", cyc - lastb, 3*N-1);
    t = 0;
    while (n < NN && t < 200) begin
      if (hold) chk("stable", out_data, held);
      chk("valid_drain", {out_valid, in_ready}, 2'b10);
      out_ready = $urandom_range(99) >= stall;
      if (out_ready) begin
        got[n] = out_data;
        n++;
        hold = 0;
      end else begin
        hold = 1;
        held = out_data;
      end
      if (abort == 2 && n == 2) begin
        do_abort();
        return;
      end
      @(negedge clk);
      t++;
    end
    out_ready = 0;
    chk("done_pulse", {done, out_valid, busy, in_ready}, 4'b1001);
    @(negedge clk);
    chk("done_low", done, 0);
    for (int e = 0; e < NN; e++) chk($sformatf("c[%0d]", e), got[e], mc[e]);
  endtask

  task automatic rand_mats();
    for (int e = 0; e < NN; e++) begin
      ma[e] = DW'($urandom());
      mb[e] = DW'($urandom());
    end
  endtask

  initial begin
    logic [AW-1:0] exp [NN];
    rst = 1; in_valid = 0; out_ready = 0; acc_keep = 0; in_data = '0;
    for (int e = 0; e < NN; e++) mc[e] = '0;
    repeat (3) @(negedge clk);
    chk("reset_state", {in_ready, out_valid, busy, done}, 4'b1000);
    chk("reset_out_data", out_data, 0);
    rst = 0;
    ma = '{1, 2, 3, 4}; mb = '{5, 6, 7, 8};
    run_job(0, 0, 0, 0);
    exp = '{19, 22, 43, 50};
    for (int e = 0; e < NN; e++) chk("basic", got[e], exp[e]);
    run_job(1, 0, 0, 0);
    exp = '{38, 44, 86, 100};
    for (int e = 0; e < NN; e++) chk("keep", got[e], exp[e]);
    ma = '{1, 0, 0, 1}; mb = '{1, 2, 3, 4};
    run_job(0, 40, 40, 0);
    exp = '{1, 2, 3, 4};
    for (int e = 0; e < NN; e++) chk("identity", got[e], exp[e]);
    ma = '{255, 255, 255, 255}; mb = '{255, 255, 255, 255};
    run_job(0, 0, 0, 0);
`ifndef SYSMM_SIGNED_EN
    for (int e = 0; e < NN; e++) chk("max_operands", got[e], 130050);
`endif
    run_job(1, 10, 10, 0);
    run_job(1, 10, 10, 0);
`ifndef SYSMM_SIGNED_EN
    for (int e = 0; e < NN; e++) chk("wrap", got[e], 128006);
`endif
    rand_mats();
    run_job(0, 20, 0, 1);
    rand_mats();
    run_job(1, 20, 20, 0);
    run_job(0, 10, 30, 2);
    rand_mats();
    run_job(1, 20, 20, 0);
    repeat (8) begin
      rand_mats();
      run_job(1'($urandom_range(1)), 30, 30, 0);
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", cmp, bad);
    $finish;
  end
endmodule
